// File: rtl/snake_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_game_pkg
//  Description : Shared types and constants for the snake game-flow
//                controller: state encoding, winner codes, USB keycodes
//                and small arithmetic helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_game_pkg;

    // Game-flow states; the encoding is visible on the state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Winner encoding shown on the winner output.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // USB HID usage codes for the control keys.
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;

    // Scores drive a single HEX digit, so they stop at 9.
    localparam logic [3:0] SCORE_MAX = 4'd9;

    // Saturating score increment.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? s : s + 4'd1;
    endfunction

    // Absolute distance between two unsigned 10-bit coordinates, done in
    // 11-bit signed so the difference cannot wrap.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[10] ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_game_ctrl_vsync_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : vsync_edge_sync
//  Description : Brings the asynchronous VGA vertical sync into the Clk
//                domain through two flops and emits a registered one-cycle
//                frame_tick on each falling edge of the synchronized signal.
//                frame_tick appears 3 Clk after vs falls at the pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsync_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic vs,
    output logic frame_tick
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_tick;

    // Synchronizer chain plus falling-edge register; vs idles high, so the
    // chain resets high to avoid a spurious tick after reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
            r_tick   <= 1'b0;
        end else begin
            r_meta   <= vs;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_tick   <= r_sync_d & ~r_sync;
        end
    end

    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_game_ctrl
//  Description : Game-flow controller for the two-player snake design.
//                Converts vertical sync into frame ticks, gates snake
//                movement into step pulses, sequences rounds from USB
//                keycodes, judges collisions and keeps per-player scores.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_game_ctrl
    import snake_game_pkg::*;
#(
    parameter int STEP_FRAMES  = 4,
    parameter int COUNT_FRAMES = 60,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int HIT_DIST     = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vs,
    input  logic [15:0] keycode,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    output logic        step,
    output logic        snake_rst,
    output logic [2:0]  state,
    output logic [1:0]  winner,
    output logic [1:0]  count_sec,
    output logic [3:0]  score1,
    output logic [3:0]  score2
);

    localparam int c_FW = (STEP_FRAMES  > 1) ? $clog2(STEP_FRAMES)  : 1;
    localparam int c_CW = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;
    localparam logic [c_FW-1:0] c_F_LAST = c_FW'(STEP_FRAMES - 1);
    localparam logic [c_CW-1:0] c_C_LAST = c_CW'(COUNT_FRAMES - 1);
    localparam logic [9:0]      c_X_MAX  = 10'(X_MAX);
    localparam logic [9:0]      c_Y_MAX  = 10'(Y_MAX);
    localparam logic [10:0]     c_HIT    = 11'(HIT_DIST);

    logic w_tick;

    vsync_edge_sync u_vsync (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .frame_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Key events
    // ------------------------------------------------------------------
    logic w_enter_held;
    logic w_p_held;
    logic w_enter_rise;
    logic r_enter_held;
    logic r_p_held;
    logic r_ev_enter;
    logic r_ev_p;

    assign w_enter_held = (keycode[15:8] == KEY_ENTER) || (keycode[7:0] == KEY_ENTER);
    assign w_p_held     = (keycode[15:8] == KEY_P)     || (keycode[7:0] == KEY_P);
    assign w_enter_rise = w_enter_held & ~r_enter_held;

    // Registered rising edges of the held keys; ENTER masks a simultaneous P.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_enter_held <= 1'b0;
            r_p_held     <= 1'b0;
            r_ev_enter   <= 1'b0;
            r_ev_p       <= 1'b0;
        end else begin
            r_enter_held <= w_enter_held;
            r_p_held     <= w_p_held;
            r_ev_enter   <= w_enter_rise;
            r_ev_p       <= w_p_held & ~r_p_held & ~w_enter_rise;
        end
    end

    // ------------------------------------------------------------------
    // Collision judgement
    // ------------------------------------------------------------------
    logic       w_out1;
    logic       w_out2;
    logic       w_head;
    logic       w_hit;
    logic [1:0] w_result;

    // Classify the current head positions into a round result.
    always_comb begin
        w_out1   = (p1_x > c_X_MAX) || (p1_y > c_Y_MAX);
        w_out2   = (p2_x > c_X_MAX) || (p2_y > c_Y_MAX);
        w_head   = (abs_diff(p1_x, p2_x) < c_HIT) && (abs_diff(p1_y, p2_y) < c_HIT);
        w_hit    = w_head || w_out1 || w_out2;
        w_result = WIN_NONE;
        if (w_head || (w_out1 && w_out2)) begin
            w_result = WIN_DRAW;
        end else if (w_out1) begin
            w_result = WIN_P2;
        end else if (w_out2) begin
            w_result = WIN_P1;
        end
    end

    // ------------------------------------------------------------------
    // Game-flow FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_next;
    logic [c_FW-1:0] r_fcnt;
    logic [c_CW-1:0] r_ccnt;
    logic [1:0]      r_count_sec;
    logic [1:0]      r_winner;
    logic [3:0]      r_score1;
    logic [3:0]      r_score2;
    logic            r_step;
    logic            r_snake_rst;

    // Next-state selection; a collision outranks a pause request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_ev_enter) w_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_tick && (r_ccnt == c_C_LAST) && (r_count_sec == 2'd1)) w_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_tick && w_hit) w_next = ST_OVER;
                else if (r_ev_p)     w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (r_ev_enter)  w_next = ST_IDLE;
                else if (r_ev_p) w_next = ST_PLAY;
            end
            ST_OVER: begin
                if (r_ev_enter) w_next = ST_COUNT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counters, scores and registered outputs, updated alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fcnt      <= '0;
            r_ccnt      <= '0;
            r_count_sec <= 2'd0;
            r_winner    <= WIN_NONE;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_step      <= 1'b0;
            r_snake_rst <= 1'b1;
        end else begin
            r_step      <= 1'b0;
            r_snake_rst <= (w_next == ST_IDLE) || (w_next == ST_COUNT);
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    // A new round starts its countdown with no winner shown.
                    if (w_next == ST_COUNT) begin
                        r_count_sec <= 2'd3;
                        r_ccnt      <= '0;
                        r_winner    <= WIN_NONE;
                    end
                end
                ST_COUNT: begin
                    if (w_tick) begin
                        if (r_ccnt == c_C_LAST) begin
                            r_ccnt      <= '0;
                            r_count_sec <= r_count_sec - 2'd1;
                            // Leaving for PLAY: first step is a full period away.
                            r_fcnt      <= '0;
                        end else begin
                            r_ccnt <= r_ccnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (w_tick) begin
                        if (w_hit) begin
                            r_winner <= w_result;
                            if (w_result == WIN_P1) r_score1 <= score_inc(r_score1);
                            if (w_result == WIN_P2) r_score2 <= score_inc(r_score2);
                        end else if (r_fcnt == c_F_LAST) begin
                            r_fcnt <= '0;
                            r_step <= 1'b1;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // PAUSE holds the frame count so PLAY resumes mid-period.
                end
            endcase
        end
    end

    assign step      = r_step;
    assign snake_rst = r_snake_rst;
    assign state     = r_state;
    assign winner    = r_winner;
    assign count_sec = r_count_sec;
    assign score1    = r_score1;
    assign score2    = r_score2;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_game_ctrl
//  Description : Directed self-checking bench for snake_game_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_game_ctrl;

    logic        Clk;
    logic        Reset;
    logic        vs;
    logic [15:0] keycode;
    logic [9:0]  p1_x, p1_y, p2_x, p2_y;
    logic        step;
    logic        snake_rst;
    logic [2:0]  state;
    logic [1:0]  winner;
    logic [1:0]  count_sec;
    logic [3:0]  score1, score2;

    int n_tests = 0;
    int n_fail  = 0;

    snake_game_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .vs        (vs),
        .keycode   (keycode),
        .p1_x      (p1_x),
        .p1_y      (p1_y),
        .p2_x      (p2_x),
        .p2_y      (p2_y),
        .step      (step),
        .snake_rst (snake_rst),
        .state     (state),
        .winner    (winner),
        .count_sec (count_sec),
        .score1    (score1),
        .score2    (score2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic clk1;
        @(posedge Clk);
        #1;
    endtask

    // One vs frame: falling edge at the start, 8 Clk long; reports steps
    // seen and the cycle index of the last one.
    task automatic frame(output int steps, output int pos);
        steps = 0;
        pos   = 0;
        vs    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            clk1();
            if (step === 1'b1) begin
                steps++;
                pos = i;
            end
            if (i == 3) vs = 1'b1;
        end
    endtask

    task automatic key(input logic [15:0] k);
        keycode = k;
        clk1();
        clk1();
    endtask

    task automatic release_keys;
        keycode = 16'h0000;
        clk1();
    endtask

    task automatic safe_heads;
        p1_x = 10'd100; p1_y = 10'd100;
        p2_x = 10'd300; p2_y = 10'd300;
    endtask

    task automatic start_round;
        int s, p;
        safe_heads();
        key(16'h0028);
        release_keys();
        for (int f = 0; f < 180; f++) frame(s, p);
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL round_start: state=%0d expected 2", state);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; vs = 1'b1; keycode = 16'h0000;
        safe_heads();
        repeat (3) clk1();
        Reset = 1'b0;
        clk1();
        n_tests++;
        if ({state, snake_rst, step, winner, count_sec, score1, score2} !==
            {3'd0, 1'b1, 1'b0, 2'b00, 2'd0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_values: st=%0d rst=%0b step=%0b win=%0d cs=%0d s1=%0d s2=%0d expected 0,1,0,0,0,0,0",
                     state, snake_rst, step, winner, count_sec, score1, score2);
        end
    endtask

    task automatic test_countdown;
        int s, p;
        keycode = 16'h0028;
        clk1();
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL enter_latency_1clk: state=%0d expected 0", state);
        end
        clk1();
        n_tests++;
        if (state !== 3'd1 || count_sec !== 2'd3 || snake_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL enter_to_count: st=%0d cs=%0d rst=%0b expected 1,3,1", state, count_sec, snake_rst);
        end
        release_keys();
        for (int f = 0; f < 60; f++) frame(s, p);
        n_tests++;
        if (count_sec !== 2'd2 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL count_60: st=%0d cs=%0d expected 1,2", state, count_sec);
        end
        for (int f = 0; f < 119; f++) frame(s, p);
        n_tests++;
        if (count_sec !== 2'd1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL count_179: st=%0d cs=%0d expected 1,1", state, count_sec);
        end
        frame(s, p);
        n_tests++;
        if (state !== 3'd2 || snake_rst !== 1'b0 || count_sec !== 2'd0) begin
            n_fail++;
            $display("FAIL count_180_play: st=%0d rst=%0b cs=%0d expected 2,0,0", state, snake_rst, count_sec);
        end
    endtask

    task automatic test_step_cadence;
        int s, p;
        for (int f = 1; f <= 8; f++) begin
            frame(s, p);
            n_tests++;
            if ((f % 4) == 0) begin
                if (s !== 1 || p !== 4) begin
                    n_fail++;
                    $display("FAIL step_frame%0d: steps=%0d pos=%0d expected 1 at 4", f, s, p);
                end
            end else if (s !== 0) begin
                n_fail++;
                $display("FAIL nostep_frame%0d: steps=%0d expected 0", f, s);
            end
        end
    endtask

    task automatic test_pause_resume;
        int s, p, total;
        frame(s, p);
        frame(s, p);
        key(16'h0013);
        n_tests++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL p_to_pause: state=%0d expected 3", state);
        end
        release_keys();
        total = 0;
        for (int f = 0; f < 10; f++) begin
            frame(s, p);
            total += s;
        end
        n_tests++;
        if (total !== 0 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL pause_hold: steps=%0d st=%0d expected 0,3", total, state);
        end
        key(16'h1300);
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL p_resume: state=%0d expected 2", state);
        end
        release_keys();
        frame(s, p);
        n_tests++;
        if (s !== 0) begin
            n_fail++;
            $display("FAIL resume_frame1: steps=%0d expected 0", s);
        end
        frame(s, p);
        n_tests++;
        if (s !== 1) begin
            n_fail++;
            $display("FAIL resume_frame2: steps=%0d expected 1", s);
        end
        key(16'h2813);
        clk1();
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL enter_p_same: state=%0d expected 2", state);
        end
        release_keys();
    endtask

    task automatic test_p1_out;
        int s, p;
        p1_x = 10'd700;
        frame(s, p);
        n_tests++;
        if (state !== 3'd4 || winner !== 2'b10 || score2 !== 4'd1 || score1 !== 4'd0 ||
            s !== 0 || snake_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_out: st=%0d win=%0d s1=%0d s2=%0d steps=%0d rst=%0b expected 4,2,0,1,0,0",
                     state, winner, score1, score2, s, snake_rst);
        end
    endtask

    task automatic test_p2_out;
        int s, p;
        start_round();
        p2_y = 10'd1020;
        frame(s, p);
        n_tests++;
        if (state !== 3'd4 || winner !== 2'b01 || score1 !== 4'd1 || score2 !== 4'd1) begin
            n_fail++;
            $display("FAIL p2_out: st=%0d win=%0d s1=%0d s2=%0d expected 4,1,1,1", state, winner, score1, score2);
        end
    endtask

    task automatic test_draws;
        int s, p;
        start_round();
        p1_x = 10'd200; p1_y = 10'd200;
        p2_x = 10'd205; p2_y = 10'd195;
        frame(s, p);
        n_tests++;
        if (state !== 3'd4 || winner !== 2'b11 || score1 !== 4'd1 || score2 !== 4'd1) begin
            n_fail++;
            $display("FAIL head_draw: st=%0d win=%0d s1=%0d s2=%0d expected 4,3,1,1", state, winner, score1, score2);
        end
        start_round();
        p1_x = 10'd700;
        p2_x = 10'd650;
        frame(s, p);
        n_tests++;
        if (state !== 3'd4 || winner !== 2'b11 || score1 !== 4'd1 || score2 !== 4'd1) begin
            n_fail++;
            $display("FAIL both_off_draw: st=%0d win=%0d s1=%0d s2=%0d expected 4,3,1,1", state, winner, score1, score2);
        end
    endtask

    task automatic test_saturation;
        int s, p;
        logic [3:0] exp1;
        for (int i = 0; i < 9; i++) begin
            start_round();
            p2_y = 10'd1020;
            frame(s, p);
            exp1 = (i >= 7) ? 4'd9 : 4'(i + 2);
            n_tests++;
            if (score1 !== exp1 || winner !== 2'b01) begin
                n_fail++;
                $display("FAIL score_sat_%0d: s1=%0d win=%0d expected %0d,1", i, score1, winner, exp1);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        int s, p;
        safe_heads();
        key(16'h0028);
        release_keys();
        for (int f = 0; f < 5; f++) frame(s, p);
        Reset = 1'b1;
        clk1();
        n_tests++;
        if (state !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0 || count_sec !== 2'd0 ||
            snake_rst !== 1'b1 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_count: st=%0d s1=%0d s2=%0d cs=%0d rst=%0b win=%0d expected 0,0,0,0,1,0",
                     state, score1, score2, count_sec, snake_rst, winner);
        end
        Reset = 1'b0;
        clk1();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_step_cadence();
        test_pause_resume();
        test_p1_out();
        test_p2_out();
        test_draws();
        test_saturation();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-flow controller for the two-player snake design. It turns VGA vertical sync into frame ticks and gates snake movement into step pulses. It sequences rounds (idle, countdown, play, pause, game over) from USB keycodes, judges collisions from the two head positions, and keeps per-player scores for the HEX displays. It sits between the VGA controller / USB keycode PIO and the two snake instances.

## Interface
Parameters:
- STEP_FRAMES, 4 — frames per snake step (≥1)
- COUNT_FRAMES, 60 — frames per countdown second
- X_MAX, 639 — largest legal head X
- Y_MAX, 479 — largest legal head Y
- HIT_DIST, 8 — head-to-head collision radius, pixels

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50)
- Reset  in  1  synchronous, active-high
- vs  in  1  VGA vertical sync, active low, asynchronous to Clk
- keycode  in  16  two USB HID keycode slots, [15:8] and [7:0]
- p1_x, p1_y, p2_x, p2_y  in  10 each  snake head positions, unsigned
- step  out  1  one-Clk pulse: snakes advance one step
- snake_rst  out  1  high while snakes must hold spawn position
- state  out  3  current state encoding
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- count_sec  out  2  countdown seconds remaining (3..1), 0 otherwise
- score1, score2  out  4  round wins per player, 0–9

## Operation
- Frame tick: vs passes through a 2-flop synchronizer. A falling edge of the synchronized vs gives a one-cycle frame_tick.
- Key events: ENTER=8'h28, P=8'h13. A key is "held" if either slot equals its code. An event is the rising edge of held, registered. Both keys rising in the same cycle: ENTER wins, P is dropped.
- States:
  - IDLE (0): snake_rst=1, winner=00. ENTER → COUNT.
  - COUNT (1): snake_rst=1. count_sec loads 3 on entry and decrements every COUNT_FRAMES ticks. Tick while count_sec=1 at end of its second → PLAY. ENTER ignored.
  - PLAY (2): snake_rst=0. The frame counter 0..STEP_FRAMES-1 advances per tick; step fires on wrap. On each tick, collision check, then P → PAUSE.
  - PAUSE (3): no step, frame counter held. P → PLAY. ENTER → IDLE with scores kept.
  - OVER (4): snake_rst=0, no step, winner held. ENTER → COUNT for the next round.
- Collision check (PLAY, on frame_tick):
  - out1 = p1_x>X_MAX or p1_y>Y_MAX. out2 likewise for P2.
  - head = |p1_x−p2_x|<HIT_DIST and |p1_y−p2_y|<HIT_DIST, computed in 11-bit signed.
  - head, or out1 and out2 together → draw. Otherwise out1 → P2 wins, out2 → P1 wins.
  - On any collision → OVER. Winner's score +1, saturating at 9. Draw scores nothing.
- Collision takes priority over P in the same cycle.
- Reset (any state, any time): IDLE, scores 0, counters 0, all outputs at IDLE values.

## Timing
- Reset values: state=0, snake_rst=1, step=0, winner=00, count_sec=0, score1=score2=0.
- frame_tick is asserted 3 Clk after the vs falling edge reaches the input pin. step is asserted the cycle after frame_tick.
- A key event is seen 1 Clk after keycode changes. The state updates 1 Clk after the event, so outputs change 2 Clk after keycode changes.
- The PLAY frame counter clears on entry from COUNT, so the first step comes STEP_FRAMES ticks after entry. Entry from PAUSE resumes the held count.
- All outputs are registered. step is high for exactly 1 Clk.

## Structure
- Package snake_game_pkg holds:
  - state enum (IDLE, COUNT, PLAY, PAUSE, OVER)
  - winner encoding constants
  - KEY_ENTER, KEY_P constants
- Sub-module vsync_edge_sync: 2-flop synchronizer plus falling-edge detector producing frame_tick. It is reused by any Clk-domain consumer of vs.
- Top of block holds the FSM, frame/countdown counters, collision comparators and score registers.

## Test plan
- Reset then keycode=16'h0028 → COUNT after 2 Clk, count_sec=3. After 180 vs falling edges (defaults) → PLAY, snake_rst=0.
- PLAY with heads (100,100)/(300,300): step pulses every 4th frame_tick, 1 Clk wide, each 4 Clk after its vs falling edge.
- p1_x=700 on a tick → OVER, winner=10, score2=1. Same with p2_y=1020 → winner=01, score1=1.
- Heads (200,200)/(205,195) → winner=11, scores unchanged. Both heads off-screen → draw.
- P during PLAY → PAUSE, no step for 10 frames. P again → steps resume with the frame count preserved. keycode=16'h2813 in PLAY → only ENTER acted on, which is ignored in PLAY.
- score1=9 plus another P1 win → stays 9. Reset asserted mid-COUNT → IDLE, scores 0, next cycle.
